// File: rtl/vgg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vgg_pkg
// Brief    : Shared widths, FSM state encoding and ReLU helper for the VGG16
//            datapath stages.
// Revision : 1.0 - initial release
// ============================================================================
package vgg_pkg;

    localparam int c_data_width = 32;
    localparam int c_cnt_w      = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // True when the pixel passes through ReLU unchanged (sign bit clear).
    function automatic logic relu_pass(input logic sign_bit);
        return ~sign_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pool_pos_tracker
// Brief    : Raster row/column tracking with stride phase counters; flags
//            stride-aligned window completion and the last pixel of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module pool_pos_tracker
    import vgg_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int POOL_K = 3,
    parameter int STRIDE = 2,
    parameter int CNT_W  = c_cnt_w
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_adv,
    output logic o_win_flag,
    output logic o_eof
);

    localparam logic [CNT_W-1:0] c_k_edge   = CNT_W'(POOL_K - 1);
    localparam logic [CNT_W-1:0] c_ph_last  = CNT_W'(STRIDE - 1);
    localparam logic [CNT_W-1:0] c_col_last = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] c_row_last = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col_ph;
    logic [CNT_W-1:0] r_row_ph;
    logic             w_col_last;
    logic             w_row_last;

    assign w_col_last = (r_col == c_col_last);
    assign w_row_last = (r_row == c_row_last);
    assign o_eof      = w_col_last & w_row_last;

    // Phase counters hold (pos - (K-1)) mod STRIDE once pos reaches K-1.
    assign o_win_flag = (r_row >= c_k_edge) && (r_col >= c_k_edge) &&
                        (r_row_ph == '0) && (r_col_ph == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (i_clear) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (i_adv) begin
            if (w_col_last) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (w_row_last) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row <= r_row + CNT_W'(1);
                    if (r_row >= c_k_edge)
                        r_row_ph <= (r_row_ph == c_ph_last) ? '0 : r_row_ph + CNT_W'(1);
                end
            end else begin
                r_col <= r_col + CNT_W'(1);
                if (r_col >= c_k_edge)
                    r_col_ph <= (r_col_ph == c_ph_last) ? '0 : r_col_ph + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_pool_feeder.sv
`default_nettype none
// ============================================================================
// Module   : relu_pool_feeder
// Brief    : ReLU stage feeding the 3x3 max-pool; frame FSM, window strobe
//            delay line, window count and overrun status.
// Revision : 1.0 - initial release
// ============================================================================
module relu_pool_feeder
    import vgg_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int POOL_K     = 3,
    parameter int STRIDE     = 2,
    parameter int WIN_DLY    = 2,
    parameter int CNT_W      = c_cnt_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_win_valid,
    output logic                  o_frame_done,
    output logic [CNT_W-1:0]      o_win_cnt,
    output logic                  o_overrun
);

    state_t r_state;
    logic   w_stream;
    logic   w_accept;
    logic   w_eof;
    logic   w_win_flag;
    logic   w_win_hit;
    logic   w_win_pre;

    assign w_stream  = (r_state == ST_STREAM);
    // A restart drops the concurrent pixel unless it is the frame's last one.
    assign w_accept  = i_valid & w_stream & (~i_start | w_eof);
    assign w_win_hit = w_accept & w_win_flag;

    pool_pos_tracker #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .POOL_K (POOL_K),
        .STRIDE (STRIDE),
        .CNT_W  (CNT_W)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_start),
        .i_adv      (w_accept),
        .o_win_flag (w_win_flag),
        .o_eof      (w_eof)
    );

    generate
        if (WIN_DLY == 0) begin : g_no_dly
            assign w_win_pre = w_win_hit;
        end else begin : g_dly_line
            logic [WIN_DLY-1:0] r_dly;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dly <= '0;
                end else if (i_start) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= w_win_hit;
                    for (int i = 1; i < WIN_DLY; i++)
                        r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_win_pre = r_dly[WIN_DLY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_win_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            o_win_cnt    <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_valid      <= w_accept;
            o_frame_done <= w_accept & w_eof;
            if (w_accept)
                o_data <= relu_pass(i_data[DATA_WIDTH-1]) ? i_data : '0;
            if (i_valid && !w_stream)
                o_overrun <= 1'b1;

            if (i_start) begin
                o_win_valid <= 1'b0;
                o_win_cnt   <= '0;
            end else begin
                o_win_valid <= w_win_pre;
                if (w_win_pre)
                    o_win_cnt <= o_win_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE:   if (i_start) r_state <= ST_STREAM;
                ST_STREAM: if (w_accept && w_eof && !i_start) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/relu_pool_feeder.md
Name: relu_pool_feeder

Overview:
Stage directly upstream of the 3x3 max-pooling block in the VGG16 datapath. Takes the raw convolution output stream (one 32-bit value per cycle when valid) and applies ReLU. Tracks raster row/column position within the feature map and produces the sample-valid and window-complete strobes the pooling stage needs. Frame-based: each i_start begins a new IMG_H x IMG_W map.

Parameters:
DATA_WIDTH, 32, pixel word width; bit DATA_WIDTH-1 is the sign bit (IEEE-754 single or two's-complement).
IMG_W, 8, feature-map width in pixels (>= POOL_K).
IMG_H, 8, feature-map height in pixels (>= POOL_K).
POOL_K, 3, pooling window edge.
STRIDE, 2, pooling stride (1..POOL_K).
WIN_DLY, 2, extra cycles o_win_valid is delayed to align with the downstream window buffer (0 allowed).
CNT_W, 16, row/column/window counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_start  in  1  frame-start pulse
i_data  in  DATA_WIDTH  conv output pixel
i_valid  in  1  i_data valid this cycle
o_data  out  DATA_WIDTH  ReLU'd pixel
o_valid  out  1  o_data valid (drives the line buffer's sample enable)
o_win_valid  out  1  a complete, stride-aligned POOL_KxPOOL_K window is available
o_frame_done  out  1  one-cycle pulse: last pixel of the frame emitted
o_win_cnt  out  CNT_W  windows flagged in current/last frame
o_overrun  out  1  sticky: i_valid seen while IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; o_data=0, o_valid=0, o_win_valid=0, o_frame_done=0, o_win_cnt=0, o_overrun=0; the WIN_DLY shift register is cleared.
- FSM: IDLE -> STREAM on i_start. STREAM -> IDLE after the accepted pixel at (IMG_H-1, IMG_W-1).
- i_start in STREAM aborts the frame: counters, o_win_cnt and the pipeline cleared next cycle; the FSM stays in STREAM. An i_valid in the same cycle as this i_start is dropped.
- Last pixel + i_start in the same cycle: the last pixel completes normally (done pulse), then the FSM enters STREAM with zeroed counters.
- ReLU: o_data = 0 if i_data[DATA_WIDTH-1]=1, else i_data. -0.0 therefore maps to 0.
- Latency: o_data/o_valid are registered, 1 cycle after the accepted i_valid. o_valid=0 leaves o_data holding its last value.
- Position: col increments per accepted pixel and wraps at IMG_W-1 to 0, incrementing row. Row wraps at IMG_H-1, marking end of frame.
- Window flag: raised for a pixel at (r,c) when r>=POOL_K-1, c>=POOL_K-1, (r-(POOL_K-1)) mod STRIDE==0 and (c-(POOL_K-1)) mod STRIDE==0. Implement with phase counters, not a divider.
- o_win_valid = window flag delayed 1+WIN_DLY cycles; a 1-cycle pulse per window. o_win_cnt increments on the same cycle o_win_valid rises. o_win_cnt is zeroed on i_start and holds after the frame.
- o_frame_done coincides with o_valid of the last pixel. A trailing o_win_valid can follow it by WIN_DLY cycles and is still emitted after the return to IDLE.
- i_valid in IDLE: the pixel is dropped and o_overrun is set; it clears only on reset.
- Gaps in i_valid are allowed; counters advance only on accepted pixels.

Decomposition:
- Shared package vgg_pkg: DATA_WIDTH, CNT_W defaults; FSM state enum (IDLE, STREAM); relu function (sign-bit test).
- Sub-module pool_pos_tracker: row/col counters, stride phase counters, window flag and end-of-frame flag. The top holds the FSM, ReLU register, delay line and status.

Test Plan:
- Reset mid-stream (rst low at pixel 20) -> all outputs 0 immediately. Frame restarted with i_start yields exactly 9 windows.
- 8x8, K=3, S=2, WIN_DLY=2, 64 contiguous pixels -> 9 o_win_valid pulses.
  - First pulse at 1+2 cycles after pixel index 18 (r2,c2); others at pixel indices 20, 22, 34, ..., 54.
  - o_frame_done with pixel 63's o_valid; o_win_cnt=9.
- ReLU values: 0xBF800000 -> 0x00000000, 0x80000000 -> 0x00000000, 0x3F800000 -> 0x3F800000, 0x7F7FFFFF passes unchanged; each 1 cycle after input.
- Random i_valid gaps (~50% duty) over an 8x8 frame -> same 9 windows at the same pixel indices; no o_valid during gaps.
- i_start at pixel 30, then a full frame -> o_win_cnt ends at 9 (no carry-over); last pixel + i_start coincident -> o_frame_done pulse, next frame counts from (0,0).
- i_valid while IDLE -> no o_valid; o_overrun=1 and stays set through the next complete frame.
